// File: rtl/sram_responder.sv
// Instruction/data SRAM responder sharing one word array, with an MMIO window
// on the data port holding LED, synchronised switches and a compare timer.
module sram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000,
  parameter logic [31:0] MMIO_MASK  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] inst_idx, data_idx;
  logic        is_mmio, mmio_hit, data_wr;
  logic [1:0]  reg_sel;
  logic [31:0] wmask, mmio_rd, count, cmp;
  logic        led_we, count_we, cmp_we;
  logic [7:0]  sw_sync1, sw_sync2;
  logic        unused_ok;

  assign inst_idx = inst_sram_addr[ADDR_WIDTH+1:2];
  assign data_idx = data_sram_addr[ADDR_WIDTH+1:2];
  assign is_mmio  = (data_sram_addr & MMIO_MASK) == MMIO_BASE;
  assign mmio_hit = is_mmio && (data_sram_addr[15:4] == 12'd0);
  assign reg_sel  = data_sram_addr[3:2];
  assign data_wr  = data_sram_en && (|data_sram_wen);
  assign wmask    = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                     {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign led_we   = data_wr && mmio_hit && (reg_sel == 2'd0);
  assign count_we = data_wr && mmio_hit && (reg_sel == 2'd2);
  assign cmp_we   = data_wr && mmio_hit && (reg_sel == 2'd3);

  // The instruction port never writes; its write-side pins are intentionally dead.
  assign unused_ok = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[1:0],
                       inst_sram_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    mmio_rd = 32'd0;
    if (mmio_hit) begin
      case (reg_sel)
        2'd0:    mmio_rd = {16'd0, led};
        2'd1:    mmio_rd = {24'd0, sw_sync2};
        2'd2:    mmio_rd = count;
        default: mmio_rd = cmp;
      endcase
    end
  end

  // RAM is never reset; an edge that sees rst high drops the write.
  always_ff @(posedge clk) begin
    if (!rst && data_wr && !is_mmio) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  // Non-blocking reads give read-first behaviour against a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_sram_rdata <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      if (inst_sram_en) inst_sram_rdata <= mem[inst_idx];
      if (data_sram_en) data_sram_rdata <= is_mmio ? mmio_rd : mem[data_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led       <= 16'd0;
      count     <= 32'd0;
      cmp       <= 32'hFFFF_FFFF;
      timer_irq <= 1'b0;
      sw_sync1  <= 8'd0;
      sw_sync2  <= 8'd0;
    end else begin
      sw_sync1 <= switch;
      sw_sync2 <= sw_sync1;
      if (led_we)
        led <= (led & ~wmask[15:0]) | (data_sram_wdata[15:0] & wmask[15:0]);
      count <= count_we ? ((count & ~wmask) | (data_sram_wdata & wmask)) : count + 32'd1;
      if (cmp_we)
        cmp <= (cmp & ~wmask) | (data_sram_wdata & wmask);
      // A CMP write acknowledges the interrupt even if the old values match.
      if (cmp_we)              timer_irq <= 1'b0;
      else if (count == cmp)   timer_irq <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// Randomised scoreboard bench for sram_responder against a word-level reference model.
module tb_sram_responder;
  localparam logic [31:0] BASE = 32'hBFAF_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0000;
  localparam int NWORDS = 72;

  logic        clk, rst;
  logic        inst_sram_en, data_sram_en;
  logic [3:0]  inst_sram_wen, data_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic        timer_irq;

  sram_responder dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .switch(switch), .led(led), .timer_irq(timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] data;
    logic [15:0] led;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_inst, m_data, m_count, m_cmp;
  logic [15:0] m_led;
  logic        m_irq;
  logic [7:0]  m_sw1, m_sw2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input int i);
    return m_mem.exists(i) ? m_mem[i] : 32'd0;
  endfunction

  task automatic model_reset();
    m_inst = 0; m_data = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
    m_led = 0; m_irq = 0; m_sw1 = 0; m_sw2 = 0;
  endtask

  // One clock cycle: drive at negedge, predict post-edge outputs, queue them.
  task automatic cycle(input logic ie, input logic [31:0] ia, input logic de,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    exp_t e;
    int di;
    logic mm, ok, wr, nirq;
    logic [1:0] off;
    inst_sram_en = ie; inst_sram_addr = ia;
    inst_sram_wen = 4'($urandom); inst_sram_wdata = $urandom;
    data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
    di  = int'(da[15:2]);
    mm  = ((da & MASK) == BASE);
    ok  = mm && (da[15:4] == 12'd0);
    off = da[3:2];
    wr  = de && (dw != 4'd0);
    if (ie) m_inst = rd(int'(ia[15:2]));
    if (de) begin
      if (!mm) begin
        m_data = rd(di);
        if (wr) m_mem[di] = merge(rd(di), dd, dw);
      end else if (!ok) m_data = 32'd0;
      else case (off)
        2'd0: m_data = {16'd0, m_led};
        2'd1: m_data = {24'd0, m_sw2};
        2'd2: m_data = m_count;
        default: m_data = m_cmp;
      endcase
    end
    nirq = m_irq || (m_count == m_cmp);
    if (wr && ok && off == 2'd3) begin
      m_cmp = merge(m_cmp, dd, dw);
      nirq = 1'b0;
    end
    if (wr && ok && off == 2'd2) m_count = merge(m_count, dd, dw);
    else m_count = m_count + 32'd1;
    if (wr && ok && off == 2'd0) m_led = 16'(merge({16'd0, m_led}, dd, dw));
    m_irq = nirq;
    m_sw2 = m_sw1;
    m_sw1 = switch;
    e.inst = m_inst; e.data = m_data; e.led = m_led; e.irq = m_irq;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Monitor: compares every queued expectation just after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_rdata", inst_sram_rdata, e.inst);
        check("data_rdata", data_sram_rdata, e.data);
        check("led", {16'd0, led}, {16'd0, e.led});
        check("timer_irq", {31'd0, timer_irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    logic [31:0] v, ia, da;
    logic [3:0] dw;
    rst = 1'b1;
    inst_sram_en = 0; inst_sram_wen = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    switch = 8'h00;
    model_reset();
    #1;
    check("rst_inst_rdata", inst_sram_rdata, 32'd0);
    check("rst_data_rdata", data_sram_rdata, 32'd0);
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Preload the word pool through the data port
    for (int i = 0; i < NWORDS; i++) begin
      v = (i == 16'h10) ? 32'hDEADBEEF : (i == 16'h20) ? 32'hAABBCCDD :
          (i == 16'h40) ? 32'd0 : $urandom;
      cycle(1'b0, 32'd0, 1'b1, 4'hF, 32'(i) << 2, v);
    end

    // Inst read, then hold
    cycle(1'b1, 32'h40, 1'b0, 4'd0, 32'd0, 32'd0);
    check("inst_deadbeef", m_inst, 32'hDEADBEEF);
    cycle(1'b0, 32'h44, 1'b0, 4'd0, 32'd0, 32'd0);

    // Partial write with read-first, then read back
    cycle(1'b0, 32'd0, 1'b1, 4'b0101, 32'h80, 32'h11223344);
    cycle(1'b0, 32'd0, 1'b1, 4'b0000, 32'h80, 32'd0);
    check("partial_write_model", rd(32), 32'hAA22CC44);

    // Same-cycle inst read and data write
    cycle(1'b1, 32'h100, 1'b1, 4'hF, 32'h100, 32'd5);
    cycle(1'b1, 32'h100, 1'b0, 4'd0, 32'd0, 32'd0);

    // LED write must not touch RAM word 0
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE, 32'h0000A5A5);
    cycle(1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE | 32'h10, 32'h1234);  // out-of-window write dropped
    cycle(1'b0, 32'd0, 1'b1, 4'h0, BASE | 32'h10, 32'd0);

    // Switch synchroniser latency
    switch = 8'h3C;
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 4'h0, BASE | 32'h4, 32'd0);

    // Timer compare and interrupt clear
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE | 32'h8, 32'd10);
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE | 32'hC, 32'd15);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1, 4'h0, BASE | 32'h8, 32'd0);
    check("irq_set_model", {31'd0, m_irq}, 32'd1);
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE | 32'hC, 32'd100);
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE | 32'h8, 32'd50);
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE | 32'hC, 32'd52);
    idle(1);
    cycle(1'b0, 32'd0, 1'b1, 4'h2, BASE | 32'hC, 32'h0000_0300);  // lands on a match edge
    idle(3);

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      ia = ($urandom & 32'h7FFF_0003) | (32'($urandom_range(0, NWORDS - 1)) << 2);
      if ($urandom_range(0, 3) == 0)
        da = BASE | (($urandom_range(0, 4) == 0) ? ($urandom & 32'h0000_FFFF)
                                                 : (32'($urandom_range(0, 3)) << 2));
      else
        da = ($urandom & 32'h7FFF_0003) | (32'($urandom_range(0, NWORDS - 1)) << 2);
      dw = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 15) == 0) switch = 8'($urandom);
      cycle(1'($urandom), ia, 1'($urandom), dw, da, $urandom);
    end

    // Mid-operation asynchronous reset with a write in flight
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE, 32'h0000_FFFF);
    cycle(1'b0, 32'd0, 1'b1, 4'hF, BASE | 32'h8, 32'd500);
    cycle(1'b1, 32'h0, 1'b1, 4'h0, 32'h4, 32'd0);
    data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h14;
    data_sram_wdata = 32'hBAD0BAD0;
    #3 rst = 1'b1;
    #1;
    check("mid_rst_inst_rdata", inst_sram_rdata, 32'd0);
    check("mid_rst_data_rdata", data_sram_rdata, 32'd0);
    check("mid_rst_led", {16'd0, led}, 32'd0);
    check("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
    @(negedge clk);
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
    rst = 1'b0;
    model_reset();

    // COUNT/CMP reset values and RAM survival (word 5 write was dropped)
    cycle(1'b0, 32'd0, 1'b1, 4'h0, BASE | 32'h8, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 4'h0, BASE | 32'hC, 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i) << 2, 1'b1, 4'h0, 32'(i + 1) << 2, 32'd0);
    cycle(1'b1, 32'h80, 1'b1, 4'h0, 32'h100, 32'd0);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
